mac_dot_sequencer: RTL

Sequences one signed 8x8 multiply-accumulate lane through a complete dot product of length `len`. It accepts a command, clears the accumulator, and consumes exactly `len` operand pairs from a valid/ready stream. It then presents the 32-bit sum on a valid/ready result port. It sits between the operand-fetch logic and the result writeback of the matrix multiplier; one instance drives one MAC lane.

---
 rtl/mac_seq_pkg.sv | 24 ++
 rtl/mac_seq_lane.sv | 39 +++
 rtl/mac_dot_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
// One signed 8x8 lane feeding a 32-bit accumulator.
package mac_seq_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned OP_W  = 8;

  typedef logic signed [OP_W-1:0]  operand_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Full 16-bit signed product, sign-extended to accumulator width.
  function automatic acc_t sext_product(input operand_t a, input operand_t b);
    logic signed [2*OP_W-1:0] prod;
    prod = a * b;
    return acc_t'(prod);
  endfunction

endpackage

// File: rtl/mac_seq_lane.sv
// Single MAC lane: signed 8x8 multiplier and 32-bit accumulator.
// clr has priority over en; sum wraps modulo 2^32.
module mac_seq_lane
  import mac_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  output logic signed [ACC_W-1:0] acc
);

  acc_t acc_q;
  acc_t acc_d;
  acc_t prod;

  always_comb begin
    prod  = sext_product(a, b);
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences one MAC lane through a dot product of cmd_len operand pairs and
// returns the 32-bit sum on a valid/ready result port.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned K_MAX = 256,
  parameter int unsigned LEN_W = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,

  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic signed [OP_W-1:0]  op_a,
  input  logic signed [OP_W-1:0]  op_b,

  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data,

  output logic                    busy
);

  state_e           state_q;
  state_e           state_d;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] remaining_d;

  logic cmd_hs;
  logic beat;
  logic last_beat;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign beat      = op_valid && op_ready;
  assign last_beat = beat && (remaining_q == LEN_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = (cmd_len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (last_beat) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    remaining_d = remaining_q;
    if (cmd_hs) begin
      remaining_d = cmd_len;
    end else if (beat) begin
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  // Outputs decoded from state only, so no input reaches an output combinationally.
  always_comb begin
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      StRun:   op_ready  = 1'b1;
      StDone:  res_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  mac_seq_lane u_lane (
    .clk (clk),
    .rst (rst),
    .clr (cmd_hs),
    .en  (beat),
    .a   (op_a),
    .b   (op_b),
    .acc (res_data)
  );

  // Accumulator only moves on clr/en, neither of which can fire in DONE.
  a_res_stable : assert property (
    @(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=> ($stable(res_data) && res_valid)
  );

  a_len_legal : assert property (
    @(posedge clk) disable iff (rst)
    cmd_hs |-> (cmd_len <= LEN_W'(K_MAX))
  );

  a_run_nonzero : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == StRun) |-> (remaining_q != '0)
  );

endmodule
